// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the forwarding / hazard logic.
//   - FWD_* : operand-mux select encodings (match mux input order a..d)
//   - sb_entry_t : scoreboard slot {valid, rd, reg_write, mem_read}
//   - BUBBLE : empty slot
//   - is_producer() : slot will supply a value for register r
package pipe_pkg;

  localparam int XLEN_REG = 5;

  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_EXMEM  = 2'b01;
  localparam logic [1:0] FWD_MEMWB  = 2'b10;
  localparam logic [1:0] FWD_WBHOLD = 2'b11;

  typedef struct packed {
    logic                valid;
    logic [XLEN_REG-1:0] rd;
    logic                reg_write;
    logic                mem_read;
  } sb_entry_t;

  localparam sb_entry_t BUBBLE = '0;

  // x0 is hard-wired zero, so it never has a producer.
  function automatic logic is_producer(sb_entry_t e, logic [XLEN_REG-1:0] r);
    return e.valid && e.reg_write && (e.rd == r) && (r != '0);
  endfunction

endpackage

// File: rtl/fwd_sel_calc.sv
// fwd_sel_calc: combinational operand-select for one ALU operand.
//   rs / use_rs : source index and whether it is actually read
//   ex/mem/wb   : scoreboard slots, youngest (ex) to oldest (wb)
//   sel         : 2-bit mux select (FWD_* encoding)
module fwd_sel_calc
  import pipe_pkg::*;
(
  input  logic [XLEN_REG-1:0] rs,
  input  logic                use_rs,
  input  sb_entry_t           ex,
  input  sb_entry_t           mem,
  input  sb_entry_t           wb,
  output logic [1:0]          sel
);

  // Priority order makes the youngest producer win.
  always_comb begin
    sel = FWD_RF;
    if (use_rs) begin
      if      (is_producer(ex,  rs)) sel = FWD_EXMEM;
      else if (is_producer(mem, rs)) sel = FWD_MEMWB;
      else if (is_producer(wb,  rs)) sel = FWD_WBHOLD;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: forwarding select + load-use hazard controller.
//   clk, rst (async, active low)
//   id_*        : ID-stage instruction (sources, dest, write/load flags)
//   hold        : global freeze, all state keeps its value
//   flush       : EX redirect, inserts bubble and clears selects
//   fwd_a/b_sel : registered operand-mux selects for the EX instruction
//   stall       : combinational load-use stall (hold PC/IF-ID, bubble EX)
module fwd_hazard_unit
  import pipe_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [XLEN_REG-1:0] id_rs1,
  input  logic [XLEN_REG-1:0] id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic [XLEN_REG-1:0] id_rd,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                hold,
  input  logic                flush,
  output logic [1:0]          fwd_a_sel,
  output logic [1:0]          fwd_b_sel,
  output logic                stall
);

  localparam int NUM_OPS = 2;

  sb_entry_t ex_q, mem_q, wb_q;

  logic [NUM_OPS-1:0][XLEN_REG-1:0] op_rs;
  logic [NUM_OPS-1:0]               op_use;
  logic [NUM_OPS-1:0][1:0]          sel_nxt;
  logic [NUM_OPS-1:0][1:0]          sel_q;

  assign op_rs  = {id_rs2, id_rs1};
  assign op_use = {id_use_rs2, id_use_rs1};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    fwd_sel_calc u_calc (
      .rs     (op_rs[i]),
      .use_rs (op_use[i]),
      .ex     (ex_q),
      .mem    (mem_q),
      .wb     (wb_q),
      .sel    (sel_nxt[i])
    );
  end

  // A load in EX can't forward to the next instruction; a flush kills
  // the ID instruction anyway, so no stall is needed then.
  logic lu_hit;
  assign lu_hit = ex_q.mem_read &&
                  ((id_use_rs1 && is_producer(ex_q, id_rs1)) ||
                   (id_use_rs2 && is_producer(ex_q, id_rs2)));
  assign stall  = id_valid && lu_hit && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q  <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
      sel_q <= '0;
    end else if (!hold) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (flush || stall) begin
        ex_q  <= BUBBLE;
        sel_q <= '0;
      end else begin
        ex_q  <= '{valid: id_valid, rd: id_rd,
                   reg_write: id_reg_write, mem_read: id_mem_read};
        sel_q <= sel_nxt;
      end
    end
  end

  assign fwd_a_sel = sel_q[0];
  assign fwd_b_sel = sel_q[1];

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
  logic       hold, flush;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall;

  int errors = 0;
  int checks = 0;

  fwd_hazard_unit dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .hold(hold), .flush(flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // valid, rd, reg_write, mem_read, rs1, use1, rs2, use2
  task automatic ins(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                     input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2);
    id_valid = v; id_rd = rd; id_reg_write = rw; id_mem_read = mr;
    id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
    #1;
  endtask

  task automatic nop();   ins(1, 0, 1, 0, 0, 1, 0, 0); endtask   // addi x0,x0,0
  task automatic addi(input logic [4:0] rd); ins(1, rd, 1, 0, 0, 1, 0, 0); endtask
  task automatic tick();  @(posedge clk); #1; endtask

  initial begin
    rst = 1'b0; hold = 0; flush = 0;
    ins(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_a", fwd_a_sel, 2'b00);
    chk("rst_b", fwd_b_sel, 2'b00);
    chk("rst_stall", {1'b0, stall}, 2'b00);
    @(negedge clk); rst = 1'b1;

    // distance 0: addi x5 ; add x6,x5,x5
    @(negedge clk);
    addi(5); tick();
    ins(1, 6, 1, 0, 5, 1, 5, 1); tick();
    chk("d0_a", fwd_a_sel, 2'b01);
    chk("d0_b", fwd_b_sel, 2'b01);

    // distance 1
    addi(11); tick(); nop(); tick();
    ins(1, 6, 1, 0, 11, 1, 11, 1); tick();
    chk("d1_a", fwd_a_sel, 2'b10);
    chk("d1_b", fwd_b_sel, 2'b10);

    // distance 2
    addi(12); tick(); nop(); tick(); nop(); tick();
    ins(1, 6, 1, 0, 12, 1, 12, 1); tick();
    chk("d2_a", fwd_a_sel, 2'b11);
    chk("d2_b", fwd_b_sel, 2'b11);

    // distance 3: producer has retired
    addi(13); tick(); nop(); tick(); nop(); tick(); nop(); tick();
    ins(1, 6, 1, 0, 13, 1, 13, 1); tick();
    chk("d3_a", fwd_a_sel, 2'b00);
    chk("d3_b", fwd_b_sel, 2'b00);

    // youngest wins, x0 never forwarded
    addi(7); tick(); addi(7); tick();
    ins(1, 8, 1, 0, 7, 1, 0, 1); tick();
    chk("young_a", fwd_a_sel, 2'b01);
    chk("young_b", fwd_b_sel, 2'b00);

    // load-use: lw x9 ; add x10,x9,x1
    ins(1, 9, 1, 1, 2, 1, 0, 0); tick();
    ins(1, 10, 1, 0, 9, 1, 1, 1);
    chk("lu_stall_on", {1'b0, stall}, 2'b01);
    tick();
    chk("lu_bubble_a", fwd_a_sel, 2'b00);
    chk("lu_bubble_b", fwd_b_sel, 2'b00);
    chk("lu_stall_off", {1'b0, stall}, 2'b00);
    tick();
    chk("lu_exec_a", fwd_a_sel, 2'b10);
    chk("lu_exec_b", fwd_b_sel, 2'b00);

    // flush beats stall
    ins(1, 14, 1, 1, 2, 1, 0, 0); tick();
    ins(1, 15, 1, 0, 14, 1, 14, 1);
    flush = 1; #1;
    chk("fl_stall", {1'b0, stall}, 2'b00);
    tick();
    flush = 0; #1;
    chk("fl_a", fwd_a_sel, 2'b00);
    chk("fl_b", fwd_b_sel, 2'b00);
    chk("fl_stall_after", {1'b0, stall}, 2'b00);  // EX now holds a bubble
    tick();
    chk("fl_next_a", fwd_a_sel, 2'b10);           // load now in MEM

    // hold: freeze with a=01 registered
    addi(16); tick();
    ins(1, 17, 1, 0, 16, 1, 0, 1); tick();
    chk("hold_pre_a", fwd_a_sel, 2'b01);
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      ins(1, 5'(20 + i), 1, i[0], 5'(i + 1), 1, 16, 1);
      tick();
      chk("hold_a", fwd_a_sel, 2'b01);
      chk("hold_b", fwd_b_sel, 2'b00);
    end
    ins(1, 18, 1, 0, 17, 1, 17, 1);
    hold = 0; #1;
    tick();   // EX must still hold add x17
    chk("hold_post_a", fwd_a_sel, 2'b01);
    chk("hold_post_b", fwd_b_sel, 2'b01);

    // async reset mid-operation with load-use active
    addi(21); tick();
    ins(1, 20, 1, 1, 21, 1, 0, 0); tick();
    chk("pre_rst_a", fwd_a_sel, 2'b01);
    ins(1, 22, 1, 0, 20, 1, 0, 1);
    chk("pre_rst_stall", {1'b0, stall}, 2'b01);
    hold = 1; #2;
    rst = 0; #1;
    chk("mid_rst_a", fwd_a_sel, 2'b00);
    chk("mid_rst_b", fwd_b_sel, 2'b00);
    chk("mid_rst_stall", {1'b0, stall}, 2'b00);
    @(negedge clk);
    hold = 0; rst = 1;
    ins(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("idle_a", fwd_a_sel, 2'b00);
    chk("idle_b", fwd_b_sel, 2'b00);
    chk("idle_stall", {1'b0, stall}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
